// File: rtl/uart_frame_scheduler.sv
// rtl/uart_frame_scheduler.sv - packs channel snapshots into SYNC/MASK/DATA[/CSUM] byte frames for the UART TX
// Optional checksum byte: define UART_FRAME_CHECKSUM_EN.
module uart_frame_scheduler #(
    parameter int          NUM_CH    = 3,
    parameter int          DATA_W    = 22,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                     sys_clock,
    input  logic                     reset,
    input  logic                     new_frame,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_ready,
    output logic [7:0]               tx_byte,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     busy,
    output logic                     frame_done,
    output logic [7:0]               overrun_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_MASK,
        S_DATA,
`ifdef UART_FRAME_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    state_t              state, state_n;
    logic [NUM_CH-1:0]   mask;
    logic [DATA_W-1:0]   hold [NUM_CH];
    logic [1:0]          ptr, ptr_n;
    logic [1:0]          bi, bi_n;
    logic [7:0]          tx_byte_n;
    logic                tx_valid_n;
    logic                xfer;
    logic                capture;
    logic [7:0]          mask_byte;
    logic                first_found, next_found;
    logic [1:0]          first_idx, next_idx;
    logic [DATA_W-1:0]   first_sample, next_sample, cur_sample;

    assign xfer       = tx_valid & tx_ready;
    assign capture    = (state == S_IDLE) & new_frame;
    assign ch_ready   = ch_valid & {NUM_CH{capture}};
    assign busy       = (state != S_IDLE) & (state != S_DONE);
    assign frame_done = (state == S_DONE);

    // Byte k of a channel record: channel id plus top 6 sample bits, then the two low bytes.
    function automatic logic [7:0] pack_byte(input logic [1:0] idx,
                                             input logic [DATA_W-1:0] s,
                                             input logic [1:0] b);
        case (b)
            2'd0:    return {idx, s[21:16]};
            2'd1:    return s[15:8];
            default: return s[7:0];
        endcase
    endfunction

    // Zero-extend the captured mask into the MASK byte.
    always_comb begin
        mask_byte = '0;
        mask_byte[NUM_CH-1:0] = mask;
    end

    // Locate the lowest set mask bit overall and the lowest one above the current pointer.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (mask[k]) begin
                first_found = 1'b1;
                first_idx   = 2'(k);
            end
            if (mask[k] && (k > int'(ptr))) begin
                next_found = 1'b1;
                next_idx   = 2'(k);
            end
        end
    end

    // Select the held samples for the current, first and next channels.
    always_comb begin
        first_sample = '0;
        next_sample  = '0;
        cur_sample   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (2'(k) == first_idx) first_sample = hold[k];
            if (2'(k) == next_idx)  next_sample  = hold[k];
            if (2'(k) == ptr)       cur_sample   = hold[k];
        end
    end

`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0] csum_acc;

    // Running XOR of MASK and data bytes as they are accepted.
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset)
            csum_acc <= 8'h00;
        else if (capture)
            csum_acc <= 8'h00;
        else if (xfer && (state == S_MASK || state == S_DATA))
            csum_acc <= csum_acc ^ tx_byte;
    end
`endif

    // Next state and next registered output byte; outputs only move on a transfer or on frame start.
    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        bi_n       = bi;
        tx_byte_n  = tx_byte;
        tx_valid_n = tx_valid;
        case (state)
            S_IDLE: begin
                if (new_frame) begin
                    state_n    = S_SYNC;
                    tx_byte_n  = SYNC_BYTE;
                    tx_valid_n = 1'b1;
                end
            end
            S_SYNC: begin
                if (xfer) begin
                    state_n   = S_MASK;
                    tx_byte_n = mask_byte;
                end
            end
            S_MASK, S_DATA: begin
                if (xfer) begin
                    if (state == S_DATA && bi != 2'd2) begin
                        bi_n      = bi + 2'd1;
                        tx_byte_n = pack_byte(ptr, cur_sample, bi + 2'd1);
                    end else if (state == S_MASK && first_found) begin
                        state_n   = S_DATA;
                        ptr_n     = first_idx;
                        bi_n      = 2'd0;
                        tx_byte_n = pack_byte(first_idx, first_sample, 2'd0);
                    end else if (state == S_DATA && next_found) begin
                        ptr_n     = next_idx;
                        bi_n      = 2'd0;
                        tx_byte_n = pack_byte(next_idx, next_sample, 2'd0);
                    end else begin
`ifdef UART_FRAME_CHECKSUM_EN
                        state_n   = S_CSUM;
                        tx_byte_n = csum_acc ^ tx_byte;
`else
                        state_n    = S_DONE;
                        tx_valid_n = 1'b0;
`endif
                    end
                end
            end
`ifdef UART_FRAME_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) begin
                    state_n    = S_DONE;
                    tx_valid_n = 1'b0;
                end
            end
`endif
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n    = S_IDLE;
                tx_valid_n = 1'b0;
            end
        endcase
    end

    // FSM and output registers.
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            ptr      <= '0;
            bi       <= '0;
            tx_byte  <= 8'h00;
            tx_valid <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            bi       <= bi_n;
            tx_byte  <= tx_byte_n;
            tx_valid <= tx_valid_n;
        end
    end

    // Snapshot of the mask and every channel sample at frame start.
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            mask <= '0;
            for (int k = 0; k < NUM_CH; k++) hold[k] <= '0;
        end else if (capture) begin
            mask <= ch_valid;
            for (int k = 0; k < NUM_CH; k++) hold[k] <= ch_data[k*DATA_W +: DATA_W];
        end
    end

    // Saturating count of frame requests that arrive while a frame is in progress.
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset)
            overrun_count <= 8'h00;
        else if (new_frame && state != S_IDLE && overrun_count != 8'hFF)
            overrun_count <= overrun_count + 8'h01;
    end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// tb/tb_uart_frame_scheduler.sv - self-checking bench for uart_frame_scheduler
module tb_uart_frame_scheduler;

    logic        sys_clock = 1'b0;
    logic        reset     = 1'b1;
    logic        new_frame = 1'b0;
    logic [2:0]  ch_valid  = 3'b000;
    logic [65:0] ch_data   = '0;
    logic [2:0]  ch_ready;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready  = 1'b0;
    logic        busy;
    logic        frame_done;
    logic [7:0]  overrun_count;

    uart_frame_scheduler #(.NUM_CH(3), .DATA_W(22), .SYNC_BYTE(8'hA5)) dut (
        .sys_clock     (sys_clock),
        .reset         (reset),
        .new_frame     (new_frame),
        .ch_valid      (ch_valid),
        .ch_data       (ch_data),
        .ch_ready      (ch_ready),
        .tx_byte       (tx_byte),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .busy          (busy),
        .frame_done    (frame_done),
        .overrun_count (overrun_count)
    );

    always #5 sys_clock = ~sys_clock;

    typedef struct {
        logic [2:0]  valid;
        logic [21:0] d0, d1, d2;
        int          mode;
        logic [2:0]  exp_ready;
    } vec_t;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    int         ready_mode = 0;
    int         xfer_cnt = 0;
    int         done_cnt = 0;
    logic       prev_xfer = 1'b0;
    logic       stall_prev = 1'b0;
    logic [7:0] prev_byte = 8'h00;
    vec_t       vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_model(input logic [2:0] valid, input logic [21:0] d0,
                              input logic [21:0] d1, input logic [21:0] d2);
        logic [21:0] d[3];
        logic [7:0]  acc;
        logic [7:0]  b;
        d[0] = d0; d[1] = d1; d[2] = d2;
        exp_q.push_back(8'hA5);
        acc = {5'b00000, valid};
        exp_q.push_back(acc);
        for (int k = 0; k < 3; k++) begin
            if (valid[k]) begin
                b = {2'(k), d[k][21:16]}; exp_q.push_back(b); acc ^= b;
                b = d[k][15:8];           exp_q.push_back(b); acc ^= b;
                b = d[k][7:0];            exp_q.push_back(b); acc ^= b;
            end
        end
`ifdef UART_FRAME_CHECKSUM_EN
        exp_q.push_back(acc);
`endif
    endtask

    task automatic wait_done(input int start);
        int n = 0;
        while (done_cnt == start && n < 3000) begin
            @(posedge sys_clock);
            n++;
        end
        if (done_cnt == start) begin
            checks++;
            failures++;
            $display("FAIL frame_done_timeout actual=none required=pulse");
            exp_q.delete();
        end
        @(posedge sys_clock); #1;
        check("busy_after_done", busy, 1'b0);
        check("valid_after_done", tx_valid, 1'b0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic run_frame(input logic [2:0] valid, input logic [21:0] d0, input logic [21:0] d1,
                             input logic [21:0] d2, input logic [2:0] exp_ready, input int mode);
        int start;
        ready_mode = mode;
        ch_valid   = valid;
        ch_data    = {d2, d1, d0};
        @(posedge sys_clock); #1;
        start     = done_cnt;
        new_frame = 1'b1;
        #1 check("ch_ready_capture", ch_ready, exp_ready);
        @(posedge sys_clock); #1;
        new_frame = 1'b0;
        #1 check("ch_ready_one_cycle", ch_ready, 3'b000);
        check("busy_after_capture", busy, 1'b1);
        wait_done(start);
    endtask

    initial begin
        fork
            // transmitter-side ready generator
            forever begin
                @(posedge sys_clock); #2;
                case (ready_mode)
                    0:       tx_ready = 1'b1;
                    1:       tx_ready = ~tx_ready;
                    2:       tx_ready = 1'($urandom_range(0, 1));
                    default: tx_ready = 1'b0;
                endcase
            end
            // scoreboard monitor
            forever begin
                @(negedge sys_clock);
                if (reset) begin
                    prev_xfer  = 1'b0;
                    stall_prev = 1'b0;
                end else begin
                    if (stall_prev) begin
                        check("stall_valid", tx_valid, 1'b1);
                        check("stall_byte", tx_byte, prev_byte);
                    end
                    if (frame_done) begin
                        check("done_after_last_xfer", prev_xfer, 1'b1);
                        check("done_all_bytes_sent", exp_q.size(), 0);
                        done_cnt++;
                    end
                    if (tx_valid && tx_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL extra_byte actual=%0h required=none", tx_byte);
                        end else begin
                            check("tx_byte", tx_byte, exp_q.pop_front());
                        end
                        xfer_cnt++;
                        prev_xfer = 1'b1;
                    end else begin
                        prev_xfer = 1'b0;
                    end
                    stall_prev = tx_valid && !tx_ready;
                    prev_byte  = tx_byte;
                end
            end
            begin : main
                int start;
                int sdone;
                int n;
                logic [7:0] basic[12];
                int basic_len;

                vecs[0] = '{3'b001, 22'h0F0F0F, 22'h3ABCDE, 22'h000001, 0, 3'b001};
                vecs[1] = '{3'b000, 22'h123456, 22'h2AAAAA, 22'h155555, 0, 3'b000};
                vecs[2] = '{3'b101, 22'h3FFFFF, 22'h000000, 22'h2AAAAA, 1, 3'b101};
                vecs[3] = '{3'b010, 22'h000000, 22'h1C3F81, 22'h3FFFFF, 2, 3'b010};
                vecs[4] = '{3'b110, 22'h111111, 22'h2468AC, 22'h13579B, 2, 3'b110};
                vecs[5] = '{3'b011, 22'h3E0001, 22'h00FF00, 22'h0ABCDE, 1, 3'b011};

                basic[0] = 8'hA5; basic[1] = 8'h07; basic[2] = 8'h0F; basic[3] = 8'h0F;
                basic[4] = 8'h0F; basic[5] = 8'h7A; basic[6] = 8'hBC; basic[7] = 8'hDE;
                basic[8] = 8'h80; basic[9] = 8'h00; basic[10] = 8'h01; basic[11] = 8'h91;
`ifdef UART_FRAME_CHECKSUM_EN
                basic_len = 12;
`else
                basic_len = 11;
`endif

                // reset state
                repeat (3) @(posedge sys_clock);
                #1;
                check("rst_tx_valid", tx_valid, 1'b0);
                check("rst_tx_byte", tx_byte, 8'h00);
                check("rst_busy", busy, 1'b0);
                check("rst_frame_done", frame_done, 1'b0);
                check("rst_overrun", overrun_count, 8'h00);
                reset = 1'b0;

                // basic frame against literal bytes
                for (int i = 0; i < basic_len; i++) exp_q.push_back(basic[i]);
                run_frame(3'b111, 22'h0F0F0F, 22'h3ABCDE, 22'h000001, 3'b111, 0);

                // table of masks, data and ready patterns
                for (int i = 0; i < 6; i++) begin
                    push_model(vecs[i].valid, vecs[i].d0, vecs[i].d1, vecs[i].d2);
                    run_frame(vecs[i].valid, vecs[i].d0, vecs[i].d1, vecs[i].d2,
                              vecs[i].exp_ready, vecs[i].mode);
                end

                // backpressure on the third byte, then toggling ready
                for (int i = 0; i < basic_len; i++) exp_q.push_back(basic[i]);
                ready_mode = 0;
                ch_valid   = 3'b111;
                ch_data    = {22'h000001, 22'h3ABCDE, 22'h0F0F0F};
                @(posedge sys_clock); #1;
                start     = xfer_cnt;
                sdone     = done_cnt;
                new_frame = 1'b1;
                @(posedge sys_clock); #1;
                new_frame = 1'b0;
                n = 0;
                while (xfer_cnt < start + 2 && n < 100) begin
                    @(posedge sys_clock); #1;
                    n++;
                end
                check("bp_reached_byte3", xfer_cnt, start + 2);
                ready_mode = 3;
                for (int i = 0; i < 20; i++) begin
                    @(posedge sys_clock); #1;
                    check("bp_hold_valid", tx_valid, 1'b1);
                    check("bp_hold_byte", tx_byte, 8'h0F);
                end
                ready_mode = 1;
                wait_done(sdone);

                // overrun while stalled
                push_model(3'b111, 22'h0F0F0F, 22'h3ABCDE, 22'h000001);
                ready_mode = 3;
                ch_valid   = 3'b111;
                ch_data    = {22'h000001, 22'h3ABCDE, 22'h0F0F0F};
                @(posedge sys_clock); #1;
                sdone     = done_cnt;
                new_frame = 1'b1;
                @(posedge sys_clock); #1;
                new_frame = 1'b0;
                ch_data   = {22'h155555, 22'h2AAAAA, 22'h3FFFFF};
                ch_valid  = 3'b011;
                for (int i = 0; i < 300; i++) begin
                    @(posedge sys_clock); #1;
                    new_frame = 1'b1;
                    #1 check("ovr_ch_ready", ch_ready, 3'b000);
                    @(posedge sys_clock); #1;
                    new_frame = 1'b0;
                end
                check("ovr_saturated", overrun_count, 8'hFF);
                check("ovr_still_sync", tx_byte, 8'hA5);
                ready_mode = 0;
                wait_done(sdone);
                check("ovr_held", overrun_count, 8'hFF);

                // reset in the DATA state
                push_model(3'b111, 22'h0F0F0F, 22'h3ABCDE, 22'h000001);
                ready_mode = 0;
                ch_valid   = 3'b111;
                ch_data    = {22'h000001, 22'h3ABCDE, 22'h0F0F0F};
                @(posedge sys_clock); #1;
                start     = xfer_cnt;
                new_frame = 1'b1;
                @(posedge sys_clock); #1;
                new_frame = 1'b0;
                n = 0;
                while (xfer_cnt < start + 3 && n < 100) begin
                    @(posedge sys_clock); #1;
                    n++;
                end
                check("mid_reached_data", xfer_cnt, start + 3);
                check("mid_valid_before", tx_valid, 1'b1);
                reset = 1'b1;
                #1;
                check("mid_rst_valid", tx_valid, 1'b0);
                check("mid_rst_busy", busy, 1'b0);
                check("mid_rst_overrun", overrun_count, 8'h00);
                new_frame = 1'b1;
                repeat (2) @(posedge sys_clock);
                #1;
                new_frame = 1'b0;
                exp_q.delete();
                reset = 1'b0;
                repeat (3) @(posedge sys_clock);
                #1;
                check("post_rst_idle_valid", tx_valid, 1'b0);
                check("post_rst_idle_busy", busy, 1'b0);
                push_model(3'b111, 22'h0F0F0F, 22'h3ABCDE, 22'h000001);
                run_frame(3'b111, 22'h0F0F0F, 22'h3ABCDE, 22'h000001, 3'b111, 2);
                check("post_rst_overrun", overrun_count, 8'h00);
            end
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
